// File: rtl/dtpu_core.sv
// dtpu_core: DTPU control FSM with a weight-stationary, lane-saturating matrix-vector MAC
module dtpu_core #(
  parameter int DATA_WIDTH_MAC      = 4,
  parameter int ROWS                = 8,
  parameter int COLUMNS             = 8,
  parameter int SIZE_WMEMORY        = 8196,
  parameter int SIZE_CSR            = 1024,
  parameter int DATA_WIDTH_CSR      = 8,
  parameter int DATA_WIDTH_WMEMORY  = 64,
  parameter int DATA_WIDTH_FIFO_IN  = 64,
  parameter int DATA_WIDTH_FIFO_OUT = 64
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic                           enable,
  output logic                           test_mode,
  output logic [31:0]                    csr_address,
  output logic                           csr_clk,
  output logic [DATA_WIDTH_CSR-1:0]      csr_din,
  input  logic [DATA_WIDTH_CSR-1:0]      csr_dout,
  output logic                           csr_ce,
  output logic                           csr_reset,
  output logic                           csr_we,
  output logic [31:0]                    wm_address,
  output logic                           wm_clk,
  output logic [DATA_WIDTH_WMEMORY-1:0]  wm_din,
  input  logic [DATA_WIDTH_WMEMORY-1:0]  wm_dout,
  output logic                           wm_ce,
  output logic                           wm_reset,
  output logic                           wm_we,
  input  logic                           infifo_is_empty,
  input  logic [DATA_WIDTH_FIFO_IN-1:0]  infifo_dout,
  output logic                           infifo_read,
  input  logic                           outfifo_is_full,
  output logic [DATA_WIDTH_FIFO_OUT-1:0] outfifo_din,
  output logic                           outfifo_write,
  input  logic                           cs_continue,
  output logic                           cs_done,
  output logic                           cs_idle,
  output logic                           cs_ready,
  input  logic                           cs_start,
  output logic [3:0]                     state
);
  localparam int VW = COLUMNS * DATA_WIDTH_MAC;
  localparam int LW = DATA_WIDTH_FIFO_OUT / ROWS;
  localparam int CW = $clog2(ROWS + 2);
  localparam logic [31:0] SAT = 32'((1 << LW) - 1);
  typedef enum logic [3:0] {IDLE, FETCH_CSR, WAIT_CSR, LOAD_W, READ_IN, COMPUTE, WRITE_OUT, DONE} state_t;
  state_t cur, nxt;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH_CSR-1:0] n;
  logic [VW-1:0] w [ROWS];
  logic [VW-1:0] x;
  logic [DATA_WIDTH_FIFO_OUT-1:0] y, y_next;
  logic [31:0] acc [ROWS];
  logic [DATA_WIDTH_FIFO_IN+DATA_WIDTH_WMEMORY-1:0] unused_bits;
  logic unused_sizes;
  assign unused_bits  = {infifo_dout, wm_dout};
  assign unused_sizes = (SIZE_WMEMORY > ROWS) && (SIZE_CSR > 0);
  assign test_mode     = 1'b0;
  assign csr_address   = '0;
  assign csr_clk       = clk;
  assign csr_din       = '0;
  assign csr_reset     = aresetn;
  assign csr_we        = 1'b0;
  assign wm_address    = 32'(cnt);
  assign wm_clk        = clk;
  assign wm_din        = '0;
  assign wm_reset      = aresetn;
  assign wm_we         = 1'b0;
  assign state         = cur;
  assign outfifo_din   = y;
  assign cs_idle       = cur == IDLE;
  assign cs_ready      = cs_idle && enable;
  assign csr_ce        = enable && cur == FETCH_CSR;
  assign wm_ce         = enable && cur == LOAD_W && cnt < CW'(ROWS);
  assign infifo_read   = enable && cur == READ_IN && !infifo_is_empty;
  assign outfifo_write = enable && cur == WRITE_OUT && !outfifo_is_full;
  assign cs_done       = enable && cur == DONE;
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:      nxt = cs_start ? FETCH_CSR : IDLE;
      FETCH_CSR: nxt = WAIT_CSR;
      WAIT_CSR:  nxt = csr_dout == '0 ? DONE : LOAD_W;
      LOAD_W:    nxt = cnt == CW'(ROWS) ? READ_IN : LOAD_W;
      READ_IN:   nxt = infifo_is_empty ? READ_IN : COMPUTE;
      COMPUTE:   nxt = WRITE_OUT;
      WRITE_OUT: nxt = outfifo_is_full ? WRITE_OUT : (n == DATA_WIDTH_CSR'(1) ? DONE : READ_IN);
      DONE:      nxt = cs_continue ? IDLE : DONE;
      default:   nxt = IDLE;
    endcase
  end
  // each lane is the full-precision dot product clipped to the lane maximum
  always_comb begin
    y_next = '0;
    for (int r = 0; r < ROWS; r++) begin
      acc[r] = '0;
      for (int c = 0; c < COLUMNS; c++)
        acc[r] = acc[r] + 32'(w[r][c*DATA_WIDTH_MAC +: DATA_WIDTH_MAC]) * 32'(x[c*DATA_WIDTH_MAC +: DATA_WIDTH_MAC]);
      y_next[r*LW +: LW] = acc[r] > SAT ? '1 : acc[r][LW-1:0];
    end
  end
  // weight row r arrives one cycle after its address, i.e. while cnt == r+1
  always_ff @(posedge clk) begin
    if (aresetn) begin
      cur <= IDLE;
      cnt <= '0;
      n   <= '0;
      x   <= '0;
      y   <= '0;
      for (int r = 0; r < ROWS; r++) w[r] <= '0;
    end else if (enable) begin
      cur <= nxt;
      cnt <= cur == LOAD_W ? cnt + 1'b1 : '0;
      if (cur == WAIT_CSR) n <= csr_dout;
      if (outfifo_write) n <= n - 1'b1;
      if (infifo_read) x <= infifo_dout[VW-1:0];
      if (cur == COMPUTE) y <= y_next;
      for (int r = 0; r < ROWS; r++)
        if (cur == LOAD_W && int'(cnt) == r + 1) w[r] <= wm_dout[VW-1:0];
    end
  end
endmodule

// File: tb/tb_dtpu_core.sv
// tb_dtpu_core: directed-vector bench for dtpu_core with hand-computed results
module tb_dtpu_core;
  logic clk = 0, aresetn = 1, enable = 0;
  logic test_mode, csr_clk, csr_ce, csr_reset, csr_we, wm_clk, wm_ce, wm_reset, wm_we;
  logic [31:0] csr_address, wm_address;
  logic [7:0] csr_din, csr_dout = 0;
  logic [63:0] wm_din, wm_dout = 0, infifo_dout = 0, outfifo_din;
  logic infifo_is_empty = 0, infifo_read, outfifo_is_full = 0, outfifo_write;
  logic cs_continue = 0, cs_done, cs_idle, cs_ready, cs_start = 0;
  logic [3:0] state;
  dtpu_core dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .test_mode(test_mode),
    .csr_address(csr_address), .csr_clk(csr_clk), .csr_din(csr_din), .csr_dout(csr_dout),
    .csr_ce(csr_ce), .csr_reset(csr_reset), .csr_we(csr_we),
    .wm_address(wm_address), .wm_clk(wm_clk), .wm_din(wm_din), .wm_dout(wm_dout),
    .wm_ce(wm_ce), .wm_reset(wm_reset), .wm_we(wm_we),
    .infifo_is_empty(infifo_is_empty), .infifo_dout(infifo_dout), .infifo_read(infifo_read),
    .outfifo_is_full(outfifo_is_full), .outfifo_din(outfifo_din), .outfifo_write(outfifo_write),
    .cs_continue(cs_continue), .cs_done(cs_done), .cs_idle(cs_idle), .cs_ready(cs_ready),
    .cs_start(cs_start), .state(state)
  );
  localparam logic [63:0] CAFE = 64'hCAFECAFECAFECAFE;
  localparam logic [63:0] ONES = 64'h0000000011111111;
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, t0 = 0, n_rd = 0, n_wr = 0, rd_cyc = 0, wr_cyc = 0, viol = 0, n_stb = 0;
  logic [63:0] last_din = 0, held = 0;
  logic was_stalled = 0, tog = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  always begin
    @(posedge clk);
    #2;
    if (tog) infifo_is_empty = ~infifo_is_empty;
  end
  always begin
    @(negedge clk);
    #1;
    if (csr_ce || wm_ce || infifo_read || outfifo_write || cs_done) begin
      n_stb++;
      if (!enable) viol++;
    end
    if (infifo_read) begin
      n_rd++;
      if (n_rd == 1) rd_cyc = cyc;
      if (infifo_is_empty) viol++;
    end
    if (outfifo_write) begin
      n_wr++;
      if (n_wr == 1) wr_cyc = cyc;
      last_din = outfifo_din;
      if (outfifo_is_full) viol++;
    end
    if (state == 4'd6 && was_stalled && outfifo_din !== held) viol++;
    was_stalled = state == 4'd6 && outfifo_is_full;
    held = outfifo_din;
  end
  task automatic wait_state(input logic [3:0] s, input int lim);
    int k = 0;
    while (state !== s && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("wait_state", 64'(k < lim), 64'd1);
  endtask
  task automatic launch(input logic [7:0] n, input logic [63:0] w, input logic [63:0] x, input logic hold);
    csr_dout = n;
    wm_dout = w;
    infifo_dout = x;
    n_rd = 0;
    n_wr = 0;
    @(negedge clk);
    cs_start = 1;
    t0 = cyc + 1;
    @(negedge clk);
    cs_start = hold;
  endtask
  task automatic finish_job();
    cs_start = 0;
    cs_continue = 1;
    @(negedge clk);
    cs_continue = 0;
    chk("idle_after_continue", 64'(state), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_idle_ready", 64'({cs_idle, cs_ready}), 64'b10);
    chk("rst_din", outfifo_din, 64'd0);
    chk("rst_strobes", 64'({csr_ce, wm_ce, infifo_read, outfifo_write, cs_done}), 64'd0);
    aresetn = 0;
    enable = 1;
    n_stb = 0;
    repeat (30) @(negedge clk);
    chk("idle_state", 64'(state), 64'd0);
    chk("idle_idle_ready", 64'({cs_idle, cs_ready}), 64'b11);
    chk("idle_no_strobes", 64'(n_stb), 64'd0);
    launch(8'd1, ONES, CAFE, 1'b1);
    wait_state(4'd7, 100);
    chk("j1_read_cycle", 64'(rd_cyc - t0 + 1), 64'd12);
    chk("j1_write_cycle", 64'(wr_cyc - t0 + 1), 64'd14);
    chk("j1_counts", 64'({n_rd[7:0], n_wr[7:0]}), 64'h0101);
    chk("j1_data", last_din, 64'h6666666666666666);
    chk("j1_done", 64'({cs_done, cs_idle}), 64'b10);
    repeat (3) @(negedge clk);
    chk("j1_start_held_in_done", 64'(state), 64'd7);
    finish_job();
    launch(8'd1, ONES, ~CAFE, 1'b0);
    wait_state(4'd7, 100);
    chk("j2_data", last_din, 64'h1212121212121212);
    finish_job();
    launch(8'd1, '1, CAFE, 1'b0);
    wait_state(4'd7, 100);
    chk("j3_saturate", last_din, 64'hFFFFFFFFFFFFFFFF);
    finish_job();
    viol = 0;
    outfifo_is_full = 1;
    tog = 1;
    launch(8'd3, ONES, CAFE, 1'b0);
    wait_state(4'd6, 100);
    repeat (4) @(negedge clk);
    chk("j4_stall_state", 64'(state), 64'd6);
    chk("j4_stall_hold", outfifo_din, 64'h6666666666666666);
    outfifo_is_full = 0;
    wait_state(4'd7, 200);
    tog = 0;
    infifo_is_empty = 0;
    chk("j4_reads", 64'(n_rd), 64'd3);
    chk("j4_writes", 64'(n_wr), 64'd3);
    chk("j4_data", last_din, 64'h6666666666666666);
    chk("j4_no_bad_strobe", 64'(viol), 64'd0);
    finish_job();
    launch(8'd1, ONES, CAFE, 1'b0);
    wait_state(4'd3, 20);
    for (int k = 0; k < 10 && wm_address != 32'd3; k++) @(negedge clk);
    chk("j5_addr_before", 64'(wm_address), 64'd3);
    enable = 0;
    #1;
    chk("j5_ce_off", 64'(wm_ce), 64'd0);
    repeat (5) @(negedge clk);
    chk("j5_frozen", 64'({state, wm_address[7:0]}), 64'h303);
    enable = 1;
    #1;
    chk("j5_resume", 64'({wm_ce, wm_address[7:0]}), 64'h103);
    wait_state(4'd7, 100);
    chk("j5_data", last_din, 64'h6666666666666666);
    chk("j5_no_bad_strobe", 64'(viol), 64'd0);
    finish_job();
    infifo_is_empty = 1;
    launch(8'd2, ONES, CAFE, 1'b0);
    wait_state(4'd4, 100);
    chk("j6_in_read", 64'(state), 64'd4);
    aresetn = 1;
    @(negedge clk);
    chk("j6_rst_state", 64'(state), 64'd0);
    chk("j6_rst_strobes", 64'({csr_ce, wm_ce, infifo_read, outfifo_write, cs_done}), 64'd0);
    chk("j6_rst_din", outfifo_din, 64'd0);
    aresetn = 0;
    infifo_is_empty = 0;
    @(negedge clk);
    chk("j6_after_rst", 64'({state, 3'b0, cs_idle}), 64'h01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
